// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per clock, start/busy/done handshake.
// Quotient and remainder are registered and held until the next completion.
//
// state | meaning
// IDLE  | waiting for start; results held
// CALC  | shifting/subtracting, one quotient bit per edge
// FIN   | divisor was zero; publish the saturated result next edge
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r, r_sh, r_diff, r_nx;
  logic [WIDTH-1:0] q, q_nx, dvsr;
  logic             ge, accept, last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (divisor == '0) ? FIN : CALC;
      CALC:    if (cnt == CW'(1)) state_nx = IDLE;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    accept    = (state == IDLE) && start;
    last_step = (state == CALC) && (cnt == CW'(1));
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_sh   = {r[WIDTH-1:0], q[WIDTH-1]};
    r_diff = r_sh - {1'b0, dvsr};
    ge     = (r_sh >= {1'b0, dvsr});
    r_nx   = ge ? r_diff : r_sh;
    q_nx   = {q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvsr        <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cnt  <= CW'(WIDTH);
        r    <= '0;
        q    <= dividend;
        dvsr <= divisor;
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
        r   <= r_nx;
        q   <= q_nx;
        if (last_step) begin
          quotient    <= q_nx;
          remainder   <= r_nx[WIDTH-1:0];
          div_by_zero <= 1'b0;
          done        <= 1'b1;
        end
      end else if (state == FIN) begin
        // q still holds the untouched captured dividend here
        quotient    <= '1;
        remainder   <= q;
        div_by_zero <= 1'b1;
        done        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes reference results, monitor pops on done.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk, rst_n, start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         z;
  } exp_t;
  exp_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.z));
        if (e.b != 0) begin
          check("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
          check("rem_lt_div", 32'(remainder < e.b), 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_done(input int lat);
    int n;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'(lat));
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    push_exp(a, b);
    step();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    wait_done((b == 0) ? 1 : W);
    step();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    run_div(8'd100, 8'd7);
    run_div(8'd255, 8'd1);
    run_div(8'd5, 8'd9);
    run_div(8'd0, 8'd3);
    run_div(8'd200, 8'd0);
    run_div(8'd9, 8'd3);

    // start pulsed while busy must be ignored
    wait_idle();
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    push_exp(8'd100, 8'd7);
    step();
    start = 1'b0;
    repeat (2) step();
    check("busy_mid", 32'(busy), 32'd1);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    step();
    start = 1'b0;
    wait_done(W - 3);
    repeat (15) step();
    check("no_extra", 32'(sb.size()), 32'd0);

    // start held high: every acceptance yields one result
    start = 1'b1; dividend = 8'd77; divisor = 8'd8;
    for (int c = 0; c < 28; c++) begin
      if (!busy) push_exp(8'd77, 8'd8);
      step();
    end
    start = 1'b0;
    wait_drain();
    wait_idle();
    repeat (2) step();

    // reset mid-division discards the result
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    push_exp(8'd100, 8'd7);
    step();
    start = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_q", 32'(quotient), 32'd0);
    check("mr_r", 32'(remainder), 32'd0);
    check("mr_dbz", 32'(div_by_zero), 32'd0);
    repeat (3) step();
    check("mr_done_hold", 32'(done), 32'd0);
    rst_n = 1'b1;
    repeat (12) step();
    check("mr_no_done", 32'(done), 32'd0);
    run_div(8'd36, 8'd6);

    for (int i = 0; i < 500; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 4));
        default: b = W'($urandom);
      endcase
      run_div(a, b);
    end

    wait_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
